traffic_req_ctrl: RTL
=====================

# traffic_req_ctrl

Input-conditioning and request controller that sits in front of the traffic light FSM. It generates the 1 Hz phase tick and debounces and latches the pedestrian button. It synchronizes the side-street sensor. It also monitors the FSM's green outputs and forces a sticky flashing fault mode on a conflict. The traffic FSM consumes `tick_1hz`, `ped_req` and `side_req` in place of raw pins and its own prescaler.

## Interface

Reset: one clock; reset is synchronous and active-low (`rst_n`, sampled on rising `clk`).

Parameters:
- `TICK_DIV`, default 100_000_000. `clk` cycles per tick, minimum 2.
- `DB_CYCLES`, default 1_000_000. Consecutive stable cycles required to accept a button level change, minimum 1.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous active-low reset
- `ped_btn_raw`  in  1  asynchronous pedestrian button, active high
- `traf_sense_raw`  in  1  asynchronous side-street sensor, active high
- `ped_light`  in  1  FSM walk light; serves as the pedestrian service acknowledge
- `main_g`  in  1  FSM main-street green
- `side_g`  in  1  FSM side-street green
- `tick_1hz`  out  1  one-cycle tick strobe
- `ped_req`  out  1  latched pedestrian request, pending service
- `side_req`  out  1  synchronized sensor level
- `fault`  out  1  sticky conflict flag
- `flash`  out  1  blink drive for all-yellow/red flashing while faulted

## Operation

- **Tick counter:** 0..TICK_DIV-1. Increments every cycle and wraps at TICK_DIV-1. `tick_1hz`=1 exactly in the cycle where the count equals TICK_DIV-1.
- **Synchronizers:** each raw input passes through a 2-flop synchronizer, reset value 0.
  - `side_req` is the second flop of the sensor synchronizer.
- **Debounce:** holds a stable level `db` (reset 0) and a counter (reset 0).
  - Synchronized level equal to `db`: counter clears.
  - Synchronized level differs from `db`: counter increments.
  - Counter reaching DB_CYCLES-1 while still differing: `db` flips next cycle and the counter clears.
  - A 0→1 transition of `db` is a press event, one cycle wide.
- **Pedestrian FSM:** states IDLE, PENDING, SERVING.
  - IDLE → PENDING on a press event.
  - PENDING → SERVING when `ped_light`=1.
  - SERVING → IDLE when `ped_light`=0.
  - Press events in PENDING or SERVING are absorbed; there is no queueing.
  - `ped_req` = (state==PENDING) && !fault.
- **Fault FSM:** states NORMAL, FAULT.
  - NORMAL → FAULT in the cycle after `main_g`&&`side_g` is sampled high.
  - FAULT is left only by reset.
  - Entering FAULT forces the pedestrian FSM to IDLE, and it stays there.
  - `fault` = (state==FAULT).
- **Flash:** `flash` toggles on each `tick_1hz` while in FAULT. It is held at 0 in NORMAL.

## Timing

- **Reset values:** `tick_1hz`=0, `ped_req`=0, `side_req`=0, `fault`=0, `flash`=0. All counters are 0, `db`=0, ped FSM is IDLE, fault FSM is NORMAL.
  - Reset asserted mid-operation aborts everything on the next edge, including a pending request.
- **First tick:** the first `tick_1hz` occurs TICK_DIV cycles after the first edge with `rst_n`=1. The tick period is then exactly TICK_DIV cycles.
- **`side_req` latency:** 2 cycles from a raw change.
- **`ped_req` latency:** rises 2 (sync) + DB_CYCLES + 1 cycles after a clean raw rising edge.
  - Falls 1 cycle after `ped_light` is sampled 1.
- **Bounce rejection:** a glitch shorter than DB_CYCLES synchronized cycles never changes `db`.
- **Simultaneous press event and `ped_light`=1 in IDLE:** go to PENDING. SERVING is entered on the next cycle if `ped_light` is still 1.
- **Simultaneous conflict and press:** FAULT wins; `ped_req` stays 0.
- **`fault` latency:** rises 1 cycle after the conflict sample.
  - The first `flash` toggle happens on the next `tick_1hz`, or on the same-cycle tick if the tick coincides with the FAULT-entry edge is not possible (no toggle in the entry cycle).
- **Outputs:** all outputs are registered or decoded directly from state registers. There is no combinational input-to-output path.

## Structure

- **Shared `traffic_pkg`:**
  - Ped FSM state encoding (IDLE/PENDING/SERVING).
  - Fault state encoding.
  - Default TICK_DIV and DB_CYCLES constants, which the traffic FSM also imports.
- **Sub-module `btn_debounce`:** contains the 2-flop sync, the stable-level counter and the press-event output, parameterized by DB_CYCLES.
  - Instantiated once for the button.
  - The sensor uses only a bare synchronizer.

## Test plan

Run with TICK_DIV=10, DB_CYCLES=4.

- **Reset and tick:** release reset → `tick_1hz` pulses at cycles 10, 20, 30 after release. All other outputs stay 0.
- **Clean press:** hold `ped_btn_raw`=1 for 20 cycles → `ped_req` rises at cycle 7 after the edge. Assert `ped_light` → `ped_req` drops 1 cycle later. Drop `ped_light` → state returns to IDLE.
- **Bounce:** pulse `ped_btn_raw` high for 3 cycles, then low, repeated 5 times → `ped_req` never rises.
- **Repeat press while PENDING or SERVING:** second clean press → no additional service. Exactly one `ped_req` high interval.
- **Conflict:** drive `main_g`=`side_g`=1 for one cycle → `fault`=1 next cycle and stays 1. `ped_req` is forced 0. `flash` toggles every 10 cycles. Only `rst_n`=0 clears it, and all outputs read 0 after reset.
- **Sensor and mid-operation reset:** toggle `traf_sense_raw` → `side_req` follows 2 cycles later. Assert `rst_n`=0 while PENDING → `ped_req`=0 on the next edge and the tick counter restarts.

Source files
------------

// File: rtl/traffic_req_ctrl_pkg.sv
// Shared encodings and defaults for the traffic light
// controller and its input-conditioning front end.
package traffic_pkg;

  localparam int TICK_DIV_DEF  = 100_000_000;
  localparam int DB_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    PED_IDLE,
    PED_PENDING,
    PED_SERVING
  } ped_st_e;

  typedef enum logic {
    FLT_NORMAL,
    FLT_FAULT
  } flt_st_e;

  // Counter width that stays legal for tiny terminal counts.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/traffic_req_ctrl_if.sv
// Conditioned-request bundle between the raw pins,
// the traffic FSM and the request controller.
interface traffic_req_ctrl_if;
  logic ped_btn_raw;
  logic traf_sense_raw;
  logic ped_light;
  logic main_g;
  logic side_g;
  logic tick_1hz;
  logic ped_req;
  logic side_req;
  logic fault;
  logic flash;

  modport master (
    output ped_btn_raw, traf_sense_raw,
    output ped_light, main_g, side_g,
    input  tick_1hz, ped_req, side_req,
    input  fault, flash
  );

  modport slave (
    input  ped_btn_raw, traf_sense_raw,
    input  ped_light, main_g, side_g,
    output tick_1hz, ped_req, side_req,
    output fault, flash
  );
endinterface

// File: rtl/traffic_req_ctrl_btn_debounce.sv
// Button synchronizer plus stable-level debouncer;
// emits a one-cycle press on each accepted 0->1 change.
module btn_debounce
  import traffic_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = cnt_w(DB_CYCLES);

  logic          s1, s2;
  logic          db, db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = db & ~db_q;

endmodule

// File: rtl/traffic_req_ctrl.sv
// Tick prescaler, pedestrian request latch, sensor sync
// and sticky green-conflict monitor for the traffic FSM.
module traffic_req_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input logic              clk,
  input logic              rst_n,
  traffic_req_ctrl_if.slave bus
);

  localparam int TW = cnt_w(TICK_DIV);

  logic [TW-1:0] tcnt;
  logic          tick;
  logic          ss1, ss2;
  logic          press;
  logic          conflict;
  logic          flash_q;
  ped_st_e       ped_st, ped_nx;
  flt_st_e       flt_st, flt_nx;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.ped_btn_raw),
    .press (press)
  );

  assign tick     = (tcnt == TW'(TICK_DIV - 1));
  assign conflict = bus.main_g & bus.side_g;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt    <= '0;
      ss1     <= 1'b0;
      ss2     <= 1'b0;
      flash_q <= 1'b0;
      ped_st  <= PED_IDLE;
      flt_st  <= FLT_NORMAL;
    end else begin
      tcnt    <= tick ? '0 : tcnt + TW'(1);
      ss1     <= bus.traf_sense_raw;
      ss2     <= ss1;
      ped_st  <= ped_nx;
      flt_st  <= flt_nx;
      // Blink only once latched; the entry edge never toggles.
      if (flt_st == FLT_NORMAL)
        flash_q <= 1'b0;
      else if (tick)
        flash_q <= ~flash_q;
    end
  end

  always_comb begin
    ped_nx = ped_st;
    flt_nx = flt_st;
    if (conflict)
      flt_nx = FLT_FAULT;
    if (flt_st == FLT_FAULT || conflict) begin
      ped_nx = PED_IDLE;
    end else begin
      unique case (1'b1)
        ped_st == PED_IDLE:
          if (press) ped_nx = PED_PENDING;
        ped_st == PED_PENDING:
          if (bus.ped_light) ped_nx = PED_SERVING;
        ped_st == PED_SERVING:
          if (!bus.ped_light) ped_nx = PED_IDLE;
        default:
          ped_nx = PED_IDLE;
      endcase
    end
  end

  assign bus.tick_1hz = tick;
  assign bus.side_req = ss2;
  assign bus.fault    = (flt_st == FLT_FAULT);
  assign bus.ped_req  = (ped_st == PED_PENDING) &&
                        (flt_st != FLT_FAULT);
  assign bus.flash    = flash_q;

endmodule
